// File: rtl/uart_rx_timer_pkg.sv
// Shared types and constants for the UART receive bit-timing engine.
package uart_rx_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HALF   = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      KIND_START  = 2'd0,
      KIND_DATA   = 2'd1,
      KIND_PARITY = 2'd2,
      KIND_STOP   = 2'd3
   } kind_e;

   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/uart_rx_bit_timer_tick_gen.sv
// Free-running period counter that pulses once every 'target' enabled cycles.
module bit_tick_gen #(
   parameter int PERIOD_BITS = 14
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   clear_i,
   input  logic                   enable_i,
   input  logic [PERIOD_BITS-1:0] target_i,
   output logic                   tick_o
);

   logic [PERIOD_BITS-1:0] count_q, count_d;

   // A clear suppresses the tick so a cancel can never leak a strobe.
   assign tick_o = enable_i && !clear_i && (count_q == target_i - PERIOD_BITS'(1));

   always_comb begin
      count_d = count_q;
      if (clear_i || tick_o)
         count_d = '0;
      else if (enable_i)
         count_d = count_q + PERIOD_BITS'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/uart_rx_bit_timer.sv
// UART RX bit-timing FSM: centre-of-bit strobes, false-start rejection, abort.
module uart_rx_bit_timer
   import uart_rx_timer_pkg::*;
#(
   parameter int PERIOD_BITS = 14,
   parameter int SIZE_BITS   = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   serial_in,
   input  logic [PERIOD_BITS-1:0] bit_period,
   input  logic [SIZE_BITS-1:0]   data_size,
   input  logic                   parity_en,
   input  logic                   two_stop,
   output logic                   sample_strobe,
   output logic [1:0]             sample_kind,
   output logic [SIZE_BITS-1:0]   bit_index,
   output logic                   busy,
   output logic                   packet_done,
   output logic                   false_start
);

   state_e                 state_q, state_d;
   logic [PERIOD_BITS-1:0] period_q, period_d;
   logic [SIZE_BITS-1:0]   size_q, size_d;
   logic                   par_q, par_d;
   logic                   two_q, two_d;
   logic [SIZE_BITS-1:0]   idx_q, idx_d;
   logic                   stop2_q, stop2_d;

   logic                   tick;
   logic                   tick_clear;
   logic                   tick_en;
   logic [PERIOD_BITS-1:0] tick_target;

   assign tick_clear  = (state_q == ST_IDLE) || abort;
   assign tick_en     = (state_q == ST_HALF) || (state_q == ST_DATA) ||
                        (state_q == ST_PARITY) || (state_q == ST_STOP);
   assign tick_target = (state_q == ST_HALF) ? (period_q >> 1) : period_q;

   bit_tick_gen #(.PERIOD_BITS(PERIOD_BITS)) u_tick (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear_i  (tick_clear),
      .enable_i (tick_en),
      .target_i (tick_target),
      .tick_o   (tick)
   );

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      size_d   = size_q;
      par_d    = par_q;
      two_d    = two_q;
      idx_d    = idx_q;
      stop2_d  = stop2_q;
      if (state_q != ST_IDLE && abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start && !abort) begin
               state_d  = ST_HALF;
               period_d = (bit_period < PERIOD_BITS'(MIN_PERIOD)) ? PERIOD_BITS'(MIN_PERIOD)
                                                                  : bit_period;
               size_d   = (data_size == '0) ? SIZE_BITS'(1) : data_size;
               par_d    = parity_en;
               two_d    = two_stop;
               idx_d    = '0;
               stop2_d  = 1'b0;
            end
            ST_HALF: if (tick) state_d = serial_in ? ST_IDLE : ST_DATA;
            ST_DATA: if (tick) begin
               if (idx_q == size_q - SIZE_BITS'(1)) begin
                  state_d = par_q ? ST_PARITY : ST_STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + SIZE_BITS'(1);
               end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP: if (tick) begin
               if (two_q && !stop2_q)
                  stop2_d = 1'b1;
               else
                  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= ST_IDLE;
         period_q <= '0;
         size_q   <= '0;
         par_q    <= 1'b0;
         two_q    <= 1'b0;
         idx_q    <= '0;
         stop2_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         size_q   <= size_d;
         par_q    <= par_d;
         two_q    <= two_d;
         idx_q    <= idx_d;
         stop2_q  <= stop2_d;
      end
   end

   // Strobe qualifiers are forced to zero outside strobe cycles.
   always_comb begin
      sample_kind = 2'd0;
      if (tick) begin
         case (state_q)
            ST_DATA:   sample_kind = KIND_DATA;
            ST_PARITY: sample_kind = KIND_PARITY;
            ST_STOP:   sample_kind = KIND_STOP;
            default:   sample_kind = KIND_START;
         endcase
      end
   end

   assign sample_strobe = tick;
   assign bit_index     = (state_q == ST_DATA) ? idx_q : '0;
   assign busy          = (state_q != ST_IDLE);
   assign packet_done   = (state_q == ST_DONE) && !abort;
   assign false_start   = tick && (state_q == ST_HALF) && serial_in;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Scoreboard bench: expected events are derived from frame arithmetic per packet.
module tb_uart_rx_bit_timer;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start, abort, serial_in, parity_en, two_stop;
   logic [13:0] bit_period;
   logic [3:0]  data_size;
   logic        sample_strobe, busy, packet_done, false_start;
   logic [1:0]  sample_kind;
   logic [3:0]  bit_index;

   typedef struct {
      int cyc;
      int typ;   // 0 strobe, 1 false_start, 2 packet_done
      int kind;
      int idx;
   } ev_t;

   ev_t q[$];
   int  cyc = 0;
   int  busy_lo = 0;
   int  busy_hi = -1;
   int  compared = 0;
   int  mismatched = 0;

   uart_rx_bit_timer #(.PERIOD_BITS(14), .SIZE_BITS(4)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .start         (start),
      .abort         (abort),
      .serial_in     (serial_in),
      .bit_period    (bit_period),
      .data_size     (data_size),
      .parity_en     (parity_en),
      .two_stop      (two_stop),
      .sample_strobe (sample_strobe),
      .sample_kind   (sample_kind),
      .bit_index     (bit_index),
      .busy          (busy),
      .packet_done   (packet_done),
      .false_start   (false_start)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // Monitor: every cycle, compare DUT pulses against the head of the queue.
   always @(negedge clk) begin
      logic act, exp, exp_busy;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         compared++;
         mismatched++;
         $display("FAIL missed_event cyc=%0d typ=%0d: actual none, required at cyc %0d",
                  cyc, q[0].typ, q[0].cyc);
         void'(q.pop_front());
      end
      for (int t = 0; t < 3; t++) begin
         act = (t == 0) ? sample_strobe : (t == 1) ? false_start : packet_done;
         exp = (q.size() > 0) && (q[0].cyc == cyc) && (q[0].typ == t);
         if (exp || act) begin
            compared++;
            if (!(exp && act)) begin
               mismatched++;
               $display("FAIL pulse typ=%0d cyc=%0d: actual %0b, required %0b", t, cyc, act, exp);
            end else if (t == 0 && (sample_kind != 2'(q[0].kind) || bit_index != 4'(q[0].idx))) begin
               mismatched++;
               $display("FAIL strobe_qual cyc=%0d: actual kind=%0d idx=%0d, required kind=%0d idx=%0d",
                        cyc, sample_kind, bit_index, q[0].kind, q[0].idx);
            end
            if (exp) void'(q.pop_front());
         end
      end
      exp_busy = (cyc > busy_lo) && (cyc <= busy_hi);
      compared++;
      if (busy !== exp_busy) begin
         mismatched++;
         $display("FAIL busy cyc=%0d: actual %0b, required %0b", cyc, busy, exp_busy);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      compared++;
      if ({sample_strobe, sample_kind, bit_index, busy, packet_done, false_start} !== 10'd0) begin
         mismatched++;
         $display("FAIL %s: actual strobe=%0b kind=%0d idx=%0d busy=%0b done=%0b fs=%0b, required all 0",
                  name, sample_strobe, sample_kind, bit_index, busy, packet_done, false_start);
      end
   endtask

   task automatic push(input int c, input int typ, input int kind, input int idx);
      ev_t e;
      e.cyc = c; e.typ = typ; e.kind = kind; e.idx = idx;
      q.push_back(e);
   endtask

   // ab_off / rs_off: cycle offset from the start cycle for abort / reset, -1 = none.
   task automatic run_packet(input int bp, input int ds, input bit par, input bit two,
                             input bit fs, input int ab_off, input int rs_off,
                             input bit chg, input bit busy_starts);
      int p, n, h, t, c0, endc;
      p = (bp < 2) ? 2 : bp;
      n = (ds < 1) ? 1 : ds;
      h = p / 2;
      bit_period = 14'(bp);
      data_size  = 4'(ds);
      parity_en  = par;
      two_stop   = two;
      serial_in  = fs;
      start      = 1'b1;
      c0 = cyc;
      push(c0 + h, 0, 0, 0);
      if (fs) begin
         push(c0 + h, 1, 0, 0);
         endc = c0 + h;
      end else begin
         t = c0 + h;
         for (int k = 0; k < n; k++) begin
            t += p;
            push(t, 0, 1, k);
         end
         if (par) begin
            t += p;
            push(t, 0, 2, 0);
         end
         t += p;
         push(t, 0, 3, 0);
         if (two) begin
            t += p;
            push(t, 0, 3, 0);
         end
         endc = t + 1;
         push(endc, 2, 0, 0);
      end
      busy_lo = c0;
      busy_hi = endc;
      step();
      start = 1'b0;
      if (chg) begin
         bit_period = 14'd50;
         data_size  = 4'd3;
         parity_en  = ~par;
         two_stop   = ~two;
      end
      while (cyc <= busy_hi) begin
         if (cyc - c0 == ab_off) begin
            abort = 1'b1;
            while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
            busy_hi = cyc;
            step();
            abort = 1'b0;
         end else if (cyc - c0 == rs_off) begin
            n_rst = 1'b0;
            q.delete();
            busy_hi = -1;
            #1;
            check_zero("async_reset");
            step();
            step();
            n_rst = 1'b1;
         end else begin
            if (!fs && cyc > c0 + h) serial_in = 1'($urandom);
            if (busy_starts && ($urandom_range(0, 7) == 0 || cyc == endc)) start = 1'b1;
            step();
            start = 1'b0;
         end
      end
   endtask

   initial begin
      int bp, ds, ab, rs, span;
      bit par, two, fs;
      n_rst = 1'b0; start = 1'b0; abort = 1'b0; serial_in = 1'b1;
      parity_en = 1'b0; two_stop = 1'b0; bit_period = 14'd10; data_size = 4'd8;
      #3;
      check_zero("reset_state");
      step();
      step();
      n_rst = 1'b1;
      step();

      run_packet(10, 8, 0, 0, 0, -1, -1, 0, 0);
      step();
      run_packet(10, 8, 1, 1, 0, -1, -1, 0, 0);
      step();
      run_packet(10, 8, 0, 0, 1, -1, -1, 0, 0);
      run_packet(0, 0, 0, 0, 0, -1, -1, 1, 0);
      step();
      run_packet(10, 8, 0, 0, 0, 40, -1, 0, 0);
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 5; i++) step();
      run_packet(10, 8, 0, 0, 0, -1, 40, 0, 0);
      step();
      run_packet(10, 8, 0, 0, 0, -1, -1, 0, 1);

      for (int i = 0; i < 40; i++) begin
         bp  = $urandom_range(0, 20);
         ds  = $urandom_range(0, 9);
         par = 1'($urandom);
         two = 1'($urandom);
         fs  = ($urandom_range(0, 5) == 0);
         span = ((bp < 2) ? 2 : bp) * (((ds < 1) ? 1 : ds) + 3);
         ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, span) : -1;
         rs  = (ab < 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, span) : -1;
         run_packet(bp, ds, par, two, fs, ab, rs, 1'($urandom), 1'($urandom));
         for (int g = $urandom_range(0, 3); g > 0; g--) step();
      end

      for (int i = 0; i < 4; i++) step();
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL leftover_events: actual %0d pending, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
Parametrised bit-timing engine for the UART receiver.
- Generates one-cycle sample strobes at the centre of the start bit, each data bit, an optional parity bit, and one or two stop bits.
- Rejects false start bits.
- Sits between the start-bit edge detector and the RX shift register / stop-bit checker; the RX control FSM consumes its strobes and completion pulses.

Parameters:
PERIOD_BITS, 14, width of bit_period and of the internal period counter
SIZE_BITS, 4, width of data_size and bit_index; max data bits = 2**SIZE_BITS-1

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from start-bit edge detector; honoured only in IDLE
abort  in  1  synchronous cancel of the packet in progress
serial_in  in  1  synchronised RX line, sampled at start-bit centre
bit_period  in  PERIOD_BITS  clocks per bit; latched at start
data_size  in  SIZE_BITS  data bits per packet; latched at start
parity_en  in  1  insert a parity slot after data; latched at start
two_stop  in  1  two stop slots instead of one; latched at start
sample_strobe  out  1  one-cycle pulse at a bit centre
sample_kind  out  2  qualifies sample_strobe: 0 START, 1 DATA, 2 PARITY, 3 STOP
bit_index  out  SIZE_BITS  index of the current DATA bit (0 = first/LSB); 0 outside DATA
busy  out  1  high in every state except IDLE
packet_done  out  1  one-cycle pulse after the final stop strobe
false_start  out  1  one-cycle pulse when serial_in is high at start-bit centre

Behaviour:
- Reset (asynchronous, n_rst low): state IDLE; counter 0; latched config 0.
  - All outputs 0 on reset: sample_strobe, sample_kind, bit_index, busy, packet_done, false_start.
  - Reset mid-packet discards the packet; no done or false_start pulse is produced.
- Config latch: on accepted start, latch P = max(bit_period, 2), N = max(data_size, 1), parity_en and two_stop. Input changes mid-packet are ignored.
- Half period: H = P >> 1, which is at least 1 after clamping.
- States: IDLE, HALF, DATA, PARITY, STOP, DONE.
- Per-phase counting: the counter clears to 0 on entry to each timed phase and on every strobe. A strobe fires in the cycle where count == target-1. Target is H in HALF and P in all other timed phases.
- Timing with start seen in cycle 0:
  - START strobe in cycle H.
  - DATA k (k = 0..N-1) in cycle H+(k+1)P.
  - PARITY, if enabled, one P later.
  - STOP strobe(s) each one P later.
  - packet_done in the cycle after the last STOP strobe (state DONE), then IDLE.
- Transitions:
  - IDLE -> HALF on start & !abort.
  - HALF at strobe:
    - serial_in=1: false_start pulses in the same cycle and the next state is IDLE.
    - Otherwise: DATA.
  - DATA after the N-th strobe -> PARITY if parity_en, else STOP.
  - PARITY after its strobe -> STOP.
  - STOP after the 1st strobe -> DONE, or after the 2nd strobe if two_stop.
  - DONE -> IDLE unconditionally.
- sample_kind and bit_index are valid in the strobe cycle. bit_index increments after each DATA strobe.
- abort in any non-IDLE state: IDLE next cycle, no strobe, no packet_done. abort has priority over a same-cycle strobe.
- start while busy: ignored, including in the DONE cycle. Back-to-back packets require start in IDLE.
- abort and start together in IDLE: abort wins; the timer stays IDLE.
- Counter never wraps: it is bounded by P-1 ≤ 2**PERIOD_BITS-1.

Decomposition:
- Package uart_rx_timer_pkg:
  - state enum
  - sample_kind enum (KIND_START/DATA/PARITY/STOP)
  - MIN_PERIOD=2 constant
- Sub-module bit_tick_gen (PERIOD_BITS):
  - Inputs: clear, enable, target.
  - Output: tick.
  - Behaviour: count clears on tick or clear.
- The top level holds the FSM, the config latches, and the bit_index counter.

Test Plan:
- Basic frame: P=10, N=8, no parity, one stop; start at cycle 0, serial_in=0 at cycle 5 -> START@5, DATA@15,25,...,85 with bit_index 0..7, STOP@95, packet_done@96, busy low @97.
- Options: P=10, N=8, parity_en=1, two_stop=1 -> PARITY@95, STOP@105 and @115, packet_done@116.
- False start: serial_in=1 at cycle 5 -> false_start@5; no DATA strobe; busy low @6; no packet_done.
- Edge config: bit_period=0 and data_size=0 behave as P=2, N=1. Then change bit_period to 50 mid-packet -> START@1, DATA@3, STOP@5, done@6; timing unaffected by the change.
- Abort: abort at cycle 40 of the basic frame -> IDLE @41, no further strobes, no done. A start in the same cycle as abort in IDLE is ignored.
- Reset: n_rst low mid-DATA -> all outputs 0 immediately (asynchronous). A new start after release gives nominal timing. A start pulse during busy or during DONE is ignored.
